data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 1, extra cycles between request acceptance and response (legal range 0..15).
REQ-002 SHALL have parameter: DEPTH_WORDS, default 4096, number of 32-bit storage words (14-bit byte address space).
REQ-003 SHALL have port: clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port: req_addr  input  14  byte address.
REQ-009 SHALL have port: req_size  input  3  funct3 encoding of the access width and extension.
REQ-010 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port: rsp_valid  output  1  response available.
REQ-012 SHALL have port: rsp_ready  input  1  initiator consumes the response.
REQ-013 SHALL have port: rsp_rdata  output  32  load result, extended per req_size; 0 for stores and errors.
REQ-014 SHALL have port: rsp_err  output  1  request was misaligned or had an illegal size.

Function
REQ-015 SHALL run an FSM with states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid & req_ready, latching we, addr, size and wdata.
REQ-017 SHALL, on accept, go to WAIT if WAIT_CYCLES > 0; otherwise go straight to RESP.
REQ-018 SHALL, in WAIT, count down WAIT_CYCLES cycles and then enter RESP; rsp_valid therefore rises WAIT_CYCLES+1 cycles after accept.
REQ-019 SHALL assert rsp_valid in RESP and hold it, with rsp_rdata and rsp_err stable, until rsp_ready = 1.
REQ-020 SHALL go to IDLE on the cycle after the rsp_valid & rsp_ready handshake; there is no back-to-back accept in that cycle.
REQ-021 SHALL support load sizes: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
REQ-022 SHALL support store sizes: 000 SB, 001 SH, 010 SW; every other store size is illegal.
REQ-023 SHALL use little-endian byte lanes: addr[1:0] selects the byte, addr[1] selects the halfword, and the word index is addr[13:2] modulo DEPTH_WORDS.
REQ-024 SHALL perform a store as a read-modify-write of only the addressed bytes, committed when the request enters RESP.
REQ-025 SHALL flag misalignment for a halfword with addr[0] = 1 or a word with addr[1:0] != 0; the response then has rsp_err = 1, rsp_rdata = 0, and memory is not modified.
REQ-026 SHALL treat load sizes 011, 110 and 111 as illegal, with the same response as REQ-025.
REQ-027 SHALL ignore req_valid while not in IDLE; the initiator holds the request until it sees req_ready.

Reset
REQ-028 SHALL, with reset = 0 at a clock edge, set the state to IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and clear the wait counter.
REQ-029 SHALL drop any in-flight transaction on reset in WAIT or RESP without a response; a store not yet committed is not written.
REQ-030 SHALL leave storage contents unchanged by reset.

Structure
REQ-031 SHALL place the funct3 size encodings, the FSM state encoding, and the misalignment/legality predicates in a shared package, alongside the core's opcode constants.
REQ-032 SHALL put byte-lane logic in one combinational sub-module, byte_lane_align: load extract/extend plus store merge and byte-enable generation.

Verification
REQ-033 SHALL cover: SW 0xDEADBEEF at addr 0x0010, then LW 0x0010 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid 2 cycles after each accept (WAIT_CYCLES = 1).
REQ-034 SHALL cover: after REQ-033, SB 0x80 at 0x0011, then LB 0x0011 -> 0xFFFFFF80, LBU 0x0011 -> 0x00000080, LW 0x0010 -> 0xDEAD80EF.
REQ-035 SHALL cover: SH 0x1234 at 0x0013 -> rsp_err = 1, rsp_rdata = 0; a following LW 0x0010 -> 0xDEAD80EF (memory unchanged).
REQ-036 SHALL cover: load with size 011 at 0x0020 -> rsp_err = 1; store with size 100 -> rsp_err = 1.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready = 0 throughout; IDLE entered 1 cycle after rsp_ready = 1.
REQ-038 SHALL cover: SW 0x0000_00AA at 0x0030 accepted, reset = 0 during WAIT -> no response, req_ready = 1 after reset; LW 0x0030 returns the prior contents.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared encodings for the data-bus responder: funct3 access sizes, FSM states,
// core opcodes, and the size legality / misalignment predicates.
package data_bus_responder_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic size_legal(input logic we, input logic [2:0] size);
    if (we) return (size == F3_B) || (size == F3_H) || (size == F3_W);
    return (size == F3_B) || (size == F3_H) || (size == F3_W) ||
           (size == F3_BU) || (size == F3_HU);
  endfunction

  // size[1:0] gives the width for both signed and unsigned loads.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
    return ((size[1:0] == 2'b01) && a[0]) ||
           ((size[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/data_bus_responder_byte_lane.sv
// byte_lane_align: little-endian load extract/extend, store merge and byte enables.
module byte_lane_align
  import data_bus_responder_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en
);

  localparam int NUM_LANES = 4;

  logic [31:0] rsh;
  logic [NUM_LANES-1:0][7:0] wsh;

  assign rsh = rword >> {addr_lo, 3'b000};
  assign wsh = wdata << {addr_lo, 3'b000};

  always_comb begin
    load_data = '0;
    case (size)
      F3_B:    load_data = {{24{rsh[7]}}, rsh[7:0]};
      F3_H:    load_data = {{16{rsh[15]}}, rsh[15:0]};
      F3_W:    load_data = rword;
      F3_BU:   load_data = {24'b0, rsh[7:0]};
      F3_HU:   load_data = {16'b0, rsh[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    byte_en = '0;
    case (size)
      F3_B:    byte_en = 4'b0001 << addr_lo;
      F3_H:    byte_en = 4'b0011 << addr_lo;
      F3_W:    byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign store_word[8*i +: 8] = byte_en[i] ? wsh[i] : rword[8*i +: 8];
  end

endmodule

// File: rtl/data_bus_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_CYCLES, respond, handshake.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state;
  logic [3:0]  wait_cnt;
  bus_req_t    r_req;
  bus_req_t    cur;
  logic        cur_err;
  logic        enter_resp;
  logic [IDX_W-1:0] idx;
  logic [31:0] rword, load_data, store_word;
  logic [3:0]  byte_en;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the request commits on its accept edge, so the
  // datapath must see the live inputs while idle.
  assign cur = (state == S_IDLE) ? '{we: req_we, addr: req_addr, size: req_size, wdata: req_wdata}
                                 : r_req;
  assign cur_err = !size_legal(cur.we, cur.size) || misaligned(cur.size, cur.addr[1:0]);
  assign idx = IDX_W'({1'b0, cur.addr[13:2]} % 13'(DEPTH_WORDS));
  assign rword = mem[idx];

  assign enter_resp = ((state == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == '0));

  byte_lane_align u_lane (
    .size       (cur.size),
    .addr_lo    (cur.addr[1:0]),
    .rword      (rword),
    .wdata      (cur.wdata),
    .load_data  (load_data),
    .store_word (store_word),
    .byte_en    (byte_en)
  );

  // Storage has no reset; a store aborted by reset never reaches this write.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur.we && !cur_err) mem[idx] <= store_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          r_req     <= cur;
          req_ready <= 1'b0;
          if (WAIT_CYCLES != 0) begin
            state    <= S_WAIT;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
          end
        end
        S_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (enter_resp) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        rsp_rdata <= (cur_err || cur.we) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder with WAIT_CYCLES = 1.
module tb_data_bus_responder;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we;
  logic [13:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  data_bus_responder #(.WAIT_CYCLES(1), .DEPTH_WORDS(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, check latency, response and handshake timing.
  task automatic do_req(input string tag, input logic we, input logic [13:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
    int lat;
    logic [31:0] cap;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"}, 32'(lat), 32'd2);
    chk({tag, " data"}, rsp_rdata, exp_data);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    cap = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold data"}, rsp_rdata, cap);
      chk({tag, " hold rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " done vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, " done rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst valid", 32'(rsp_valid), 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err",   32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    do_req("sw10",   1, 14'h0010, 3'b010, 32'hDEADBEEF, 32'h0,        0, 0);
    do_req("lw10",   0, 14'h0010, 3'b010, 32'h0,        32'hDEADBEEF, 0, 0);
    do_req("sb11",   1, 14'h0011, 3'b000, 32'h00000080, 32'h0,        0, 0);
    do_req("lb11",   0, 14'h0011, 3'b000, 32'h0,        32'hFFFFFF80, 0, 0);
    do_req("lbu11",  0, 14'h0011, 3'b100, 32'h0,        32'h00000080, 0, 0);
    do_req("lw10b",  0, 14'h0010, 3'b010, 32'h0,        32'hDEAD80EF, 0, 0);
    do_req("lh12",   0, 14'h0012, 3'b001, 32'h0,        32'hFFFFDEAD, 0, 0);
    do_req("lhu12",  0, 14'h0012, 3'b101, 32'h0,        32'h0000DEAD, 0, 0);
    do_req("sh13",   1, 14'h0013, 3'b001, 32'h00001234, 32'h0,        1, 0);
    do_req("lw10c",  0, 14'h0010, 3'b010, 32'h0,        32'hDEAD80EF, 0, 0);
    do_req("lwmis",  0, 14'h0012, 3'b010, 32'h0,        32'h0,        1, 0);
    do_req("ld011",  0, 14'h0020, 3'b011, 32'h0,        32'h0,        1, 0);
    do_req("st100",  1, 14'h0020, 3'b100, 32'h55555555, 32'h0,        1, 0);
    do_req("sh12",   1, 14'h0012, 3'b001, 32'h0000CAFE, 32'h0,        0, 0);
    do_req("hold",   0, 14'h0010, 3'b010, 32'h0,        32'hCAFE80EF, 0, 5);
    do_req("sw30",   1, 14'h0030, 3'b010, 32'h11223344, 32'h0,        0, 0);

    // Abort a store with reset while it is in WAIT.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0030; req_size = 3'b010;
    req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort accepted", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort valid", 32'(rsp_valid), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort no rsp", 32'(rsp_valid), 32'd0);
    end
    do_req("lw30", 0, 14'h0030, 3'b010, 32'h0, 32'h11223344, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
